// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random stream with a bounded draw port.
// Draws use rejection sampling with a fallback after MAX_TRIES attempts.
module lfsr_rng #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'h0001,
  parameter int               OUT_WIDTH = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  input  logic [OUT_WIDTH-1:0] limit,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] rnd,
  output logic [WIDTH-1:0]     state_out,
  output logic                 lockup
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST = TW'(MAX_TRIES - 1);

  typedef enum logic {
    IDLE,
    DRAW
  } fsm_t;

  fsm_t                 fsm;
  logic [WIDTH-1:0]     state;
  logic [WIDTH-1:0]     step;
  logic [OUT_WIDTH-1:0] lim_r;
  logic [OUT_WIDTH-1:0] mask_r;
  logic [OUT_WIDTH-1:0] cand;
  logic [TW-1:0]        tries;
  logic                 accept;

  // Smallest all-ones mask covering limit-1; limit 0 means full range.
  function automatic logic [OUT_WIDTH-1:0] fill_mask(
    input logic [OUT_WIDTH-1:0] lim
  );
    logic [OUT_WIDTH-1:0] m;
    if (lim == '0) begin
      m = '1;
    end else begin
      m = lim - OUT_WIDTH'(1);
      for (int i = 0; i < OUT_WIDTH; i++) begin
        m = m | (m >> 1);
      end
    end
    return m;
  endfunction

  assign step   = {state[WIDTH-2:0], ^(state & TAPS)};
  assign cand   = state[OUT_WIDTH-1:0] & mask_r;
  assign accept = (lim_r == '0) || (cand < lim_r);

  assign state_out = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= SEED;
      fsm    <= IDLE;
      busy   <= 1'b0;
      valid  <= 1'b0;
      rnd    <= '0;
      lockup <= 1'b0;
      tries  <= '0;
      lim_r  <= '0;
      mask_r <= '0;
    end else begin
      valid  <= 1'b0;
      lockup <= 1'b0;

      unique case (1'b1)
        seed_load: state <= (seed_in == '0) ? SEED : seed_in;
        (state == '0): begin
          state  <= SEED;
          lockup <= 1'b1;
        end
        (fsm == DRAW): state <= step;
        enable: state <= step;
        default: state <= state;
      endcase

      unique case (fsm)
        IDLE: begin
          if (req) begin
            lim_r  <= limit;
            mask_r <= fill_mask(limit);
            tries  <= '0;
            busy   <= 1'b1;
            fsm    <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            rnd   <= cand;
            valid <= 1'b1;
            busy  <= 1'b0;
            fsm   <= IDLE;
          end else if (tries == LAST) begin
            // cand <= mask < 2*lim_r, so this stays below lim_r
            rnd   <= cand - lim_r;
            valid <= 1'b1;
            busy  <= 1'b0;
            fsm   <= IDLE;
          end else begin
            tries <= tries + TW'(1);
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: per-cycle reference model plus directed checks.
// Two instances: default parameters and MAX_TRIES=1.
module tb_lfsr_rng;

  localparam int TAPS = 16'hB400;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        en0 = 0, sl0 = 0, req0 = 0;
  logic [15:0] si0 = '0;
  logic [7:0]  lim0 = '0;
  logic        busy0, valid0, lock0;
  logic [7:0]  rnd0;
  logic [15:0] st0;

  logic        en1 = 0, sl1 = 0, req1 = 0;
  logic [15:0] si1 = '0;
  logic [7:0]  lim1 = '0;
  logic        busy1, valid1, lock1;
  logic [7:0]  rnd1;
  logic [15:0] st1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  lfsr_rng u0 (
    .clock(clock), .reset(reset), .enable(en0),
    .seed_load(sl0), .seed_in(si0), .req(req0),
    .limit(lim0), .busy(busy0), .valid(valid0),
    .rnd(rnd0), .state_out(st0), .lockup(lock0)
  );

  lfsr_rng #(.MAX_TRIES(1)) u1 (
    .clock(clock), .reset(reset), .enable(en1),
    .seed_load(sl1), .seed_in(si1), .req(req1),
    .limit(lim1), .busy(busy1), .valid(valid1),
    .rnd(rnd1), .state_out(st1), .lockup(lock1)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  typedef struct {
    int st;
    bit busy;
    bit valid;
    bit lockup;
    int rnd;
    int lim;
    int mask;
    int tries;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.st = 1; m.busy = 0; m.valid = 0; m.lockup = 0;
    m.rnd = 0; m.lim = 0; m.mask = 0; m.tries = 0;
    return m;
  endfunction

  function automatic int next_val(input int s);
    return ((s << 1) | ($countones(s & TAPS) & 1)) & 16'hFFFF;
  endfunction

  function automatic int mask_for(input int lm);
    int k = 0;
    if (lm == 0) return 255;
    while (((1 << k) - 1) < (lm - 1) && k < 8) k++;
    return (1 << k) - 1;
  endfunction

  function automatic model_t model_step(
    input model_t m, input bit en, input bit sl, input int si,
    input bit rq, input int lm, input int maxt);
    model_t n = m;
    int c;
    n.valid = 0;
    n.lockup = 0;
    if (sl) n.st = (si == 0) ? 1 : si;
    else if (m.st == 0) begin n.st = 1; n.lockup = 1; end
    else if (m.busy || en) n.st = next_val(m.st);
    if (!m.busy) begin
      if (rq) begin
        n.busy = 1; n.lim = lm; n.mask = mask_for(lm); n.tries = 0;
      end
    end else begin
      c = m.st & 255 & m.mask;
      if (m.lim == 0 || c < m.lim) begin
        n.rnd = c; n.valid = 1; n.busy = 0;
      end else if (m.tries + 1 >= maxt) begin
        n.rnd = c - m.lim; n.valid = 1; n.busy = 0;
      end else begin
        n.tries = m.tries + 1;
      end
    end
    return n;
  endfunction

  model_t m0 = model_reset();
  model_t m1 = model_reset();

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      m0 = model_step(m0, en0, sl0, int'(si0), req0, int'(lim0), 8);
      m1 = model_step(m1, en1, sl1, int'(si1), req1, int'(lim1), 1);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("u0.state", 32'(st0), 32'(m0.st));
      chk("u0.busy", 32'(busy0), 32'(m0.busy));
      chk("u0.valid", 32'(valid0), 32'(m0.valid));
      chk("u0.rnd", 32'(rnd0), 32'(m0.rnd));
      chk("u0.lockup", 32'(lock0), 32'(m0.lockup));
      chk("u1.state", 32'(st1), 32'(m1.st));
      chk("u1.busy", 32'(busy1), 32'(m1.busy));
      chk("u1.valid", 32'(valid1), 32'(m1.valid));
      chk("u1.rnd", 32'(rnd1), 32'(m1.rnd));
      chk("u1.lockup", 32'(lock1), 32'(m1.lockup));
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  // Drive one draw on u0 and check the result and its timing.
  task automatic draw0(input string name, input logic [7:0] lm,
                       input int exp_rnd, input int exp_k,
                       input int exp_busy);
    int k = 0;
    int nb = 0;
    req0 = 1'b1;
    lim0 = lm;
    do begin
      @(negedge clock);
      req0 = 1'b0;
      k++;
      if (busy0) nb++;
    end while (!valid0 && k < 20);
    chk({name, ".valid"}, 32'(valid0), 32'd1);
    chk({name, ".latency"}, 32'(k), 32'(exp_k));
    chk({name, ".rnd"}, 32'(rnd0), 32'(exp_rnd));
    chk({name, ".busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    int zero_seen;
    int early;
    int k;
    int nv;

    reset = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("reset.state", 32'(st0), 32'h0001);
    chk("reset.busy", 32'(busy0), 32'd0);
    chk("reset.valid", 32'(valid0), 32'd0);
    chk("reset.rnd", 32'(rnd0), 32'd0);
    chk("reset.lockup", 32'(lock0), 32'd0);

    en0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      chk("step.state", 32'(st0), 32'(1 << i));
    end
    en0 = 1'b0;

    do_reset();
    en0 = 1'b1;
    zero_seen = 0;
    early = 0;
    for (int i = 1; i <= 65535; i++) begin
      @(negedge clock);
      if (st0 == 16'h0000) zero_seen = 1;
      if (st0 == 16'h0001 && i < 65535) early = 1;
    end
    chk("period.return", 32'(st0), 32'h0001);
    chk("period.zero", 32'(zero_seen), 32'd0);
    chk("period.early", 32'(early), 32'd0);

    @(negedge clock);
    en0 = 1'b0;
    chk("period.after", 32'(st0), 32'h0002);

    sl0 = 1'b1;
    si0 = 16'h0000;
    @(negedge clock);
    chk("seed0.state", 32'(st0), 32'h0001);
    si0 = 16'h00AB;
    @(negedge clock);
    sl0 = 1'b0;
    chk("seedAB.state", 32'(st0), 32'h00AB);
    chk("seedAB.lockup", 32'(lock0), 32'd0);

    draw0("lim10", 8'd10, 6, 3, 2);

    sl0 = 1'b1;
    si0 = 16'h0001;
    @(negedge clock);
    sl0 = 1'b0;
    draw0("lim0", 8'd0, 1, 2, 1);
    draw0("lim1", 8'd1, 0, 2, 1);

    sl1 = 1'b1;
    si1 = 16'h00FF;
    @(negedge clock);
    sl1 = 1'b0;
    req1 = 1'b1;
    lim1 = 8'd129;
    @(negedge clock);
    req1 = 1'b1;
    chk("fb.busy", 32'(busy1), 32'd1);
    @(negedge clock);
    req1 = 1'b0;
    chk("fb.valid", 32'(valid1), 32'd1);
    chk("fb.rnd", 32'(rnd1), 32'd126);
    nv = 0;
    repeat (6) begin
      @(negedge clock);
      if (valid1) nv++;
    end
    chk("fb.single_valid", 32'(nv), 32'd0);
    chk("fb.idle", 32'(busy1), 32'd0);

    sl0 = 1'b1;
    si0 = 16'h00AB;
    @(negedge clock);
    sl0 = 1'b0;
    req0 = 1'b1;
    lim0 = 8'd10;
    @(negedge clock);
    req0 = 1'b0;
    chk("abort.busy_before", 32'(busy0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", 32'(busy0), 32'd0);
    chk("abort.state", 32'(st0), 32'h0001);
    @(negedge clock);
    #2 reset = 1'b1;
    nv = 0;
    k = 0;
    repeat (4) begin
      @(negedge clock);
      if (valid0) nv++;
      if (busy0) k++;
    end
    chk("abort.no_valid", 32'(nv), 32'd0);
    chk("abort.no_busy", 32'(k), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
